// File: rtl/tx_pause_gate.sv
// Holds MAC TX idle for the inter-frame gap and for flow-control pause.
// Frames pass through combinationally; pause only takes effect between frames.
module tx_pause_gate #(
  parameter int IFG_CYCLES = 12
) (
  input  logic        rst,
  input  logic        tx_clk,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  input  logic        pause_apply,
  output logic        paused,
  output logic [15:0] pause_count
);

  // state    | meaning
  // S_IDLE   | between frames, waiting for client data or pause request
  // S_XFER   | frame in progress, client bytes pass straight to the MAC
  // S_IFG    | inter-frame gap countdown after a frame's last beat
  // S_PAUSED | TX held idle by flow control
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_XFER   = 2'd1,
    S_IFG    = 2'd2,
    S_PAUSED = 2'd3
  } state_t;

  localparam logic [7:0]  IFG_LOAD = 8'(IFG_CYCLES - 1);
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  state_t      state_q, state_d;
  logic [7:0]  ifg_cnt_q, ifg_cnt_d;
  logic        paused_q;
  logic [15:0] pause_count_q, pause_count_d;

  logic xfer;
  logic last_beat;

  assign xfer      = (state_q == S_XFER);
  assign last_beat = xfer && in_valid && out_ready && in_last;

  always_comb begin
    state_d   = state_q;
    ifg_cnt_d = ifg_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (pause_apply)   state_d = S_PAUSED;
        else if (in_valid) state_d = S_XFER;
      end
      S_XFER: begin
        if (last_beat) begin
          state_d   = S_IFG;
          ifg_cnt_d = IFG_LOAD;
        end
      end
      S_IFG: begin
        if (ifg_cnt_q == 8'd0) state_d = pause_apply ? S_PAUSED : S_IDLE;
        else                   ifg_cnt_d = ifg_cnt_q - 8'd1;
      end
      S_PAUSED: begin
        if (!pause_apply) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Count entries into PAUSED only, saturating so software never sees a wrap.
  always_comb begin
    pause_count_d = pause_count_q;
    if ((state_d == S_PAUSED) && (state_q != S_PAUSED) && (pause_count_q != CNT_MAX))
      pause_count_d = pause_count_q + 16'd1;
  end

  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ifg_cnt_q     <= 8'd0;
      paused_q      <= 1'b0;
      pause_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      ifg_cnt_q     <= ifg_cnt_d;
      paused_q      <= (state_d == S_PAUSED);
      pause_count_q <= pause_count_d;
    end
  end

  // Data is zeroed outside a frame so the MAC bus never floats at X.
  assign in_ready    = xfer & out_ready;
  assign out_valid   = xfer & in_valid;
  assign out_last    = xfer & in_last;
  assign out_data    = xfer ? in_data : 8'h00;
  assign paused      = paused_q;
  assign pause_count = pause_count_q;

endmodule

// File: tb/tb_tx_pause_gate.sv
// Directed bench for tx_pause_gate: frame pass-through, IFG length, pause,
// backpressure, counter saturation and mid-frame reset.
module tb_tx_pause_gate;

  logic        rst;
  logic        tx_clk;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic        pause_apply;
  logic        paused;
  logic [15:0] pause_count;

  int n_checks = 0;
  int n_errors = 0;

  tx_pause_gate #(.IFG_CYCLES(12)) dut (
    .rst         (rst),
    .tx_clk      (tx_clk),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .pause_apply (pause_apply),
    .paused      (paused),
    .pause_count (pause_count)
  );

  initial tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge tx_clk);
    #1;
  endtask

  // Starts from IDLE; drives a frame with out_ready=1, optionally raising
  // pause_apply while byte index pause_at is on the bus.
  task automatic send_frame(input logic [7:0] b [8], input int len, input int pause_at,
                            input string tag);
    in_valid = 1'b1;
    in_data  = b[0];
    in_last  = (len == 1);
    @(negedge tx_clk);
    check({tag, "_start_latency"}, {31'd0, out_valid}, 32'd0);
    cyc();
    for (int i = 0; i < len; i++) begin
      in_data = b[i];
      in_last = (i == len - 1);
      if (i == pause_at) pause_apply = 1'b1;
      @(negedge tx_clk);
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_data"},  {24'd0, out_data},  {24'd0, b[i]});
      check({tag, "_last"},  {31'd0, out_last},  {31'd0, (i == len - 1)});
      check({tag, "_ready"}, {31'd0, in_ready},  32'd1);
      cyc();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
  endtask

  logic [7:0] fr [8];
  logic [7:0] bp_seq [8];
  logic [2:0] bp_pat;
  int gap, lat, idx;
  logic saw_ready;

  initial begin
    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1; pause_apply = 1'b0;
    #2;
    check("rst_in_ready",    {31'd0, in_ready},    32'd0);
    check("rst_out_valid",   {31'd0, out_valid},   32'd0);
    check("rst_out_last",    {31'd0, out_last},    32'd0);
    check("rst_paused",      {31'd0, paused},      32'd0);
    check("rst_pause_count", {16'd0, pause_count}, 32'd0);
    repeat (2) @(posedge tx_clk);
    @(negedge tx_clk);
    rst = 1'b0;
    cyc();

    // Plain 4-byte frame, then a queued frame: 12 IFG cycles plus one IDLE
    // cycle pass with in_ready low before the next byte is taken.
    fr = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(fr, 4, -1, "pass");
    in_valid = 1'b1; in_data = 8'h55; in_last = 1'b1;
    gap = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge tx_clk);
      if (in_ready) break;
      gap++;
      cyc();
    end
    check("pass_ifg_gap", gap, 32'd13);
    check("pass_next_data", {24'd0, out_data}, 32'h55);
    cyc();
    in_valid = 1'b0; in_last = 1'b0;
    repeat (14) cyc();

    // Pause raised on byte 2 of a 6-byte frame: frame completes, IFG runs,
    // then PAUSED with paused visible 13 cycles after the last beat cycle.
    fr = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'h00, 8'h00};
    send_frame(fr, 6, 1, "pmid");
    lat = 0; saw_ready = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge tx_clk);
      saw_ready |= in_ready;
      if (paused) begin lat = k; break; end
      cyc();
    end
    check("pmid_paused_latency", lat, 32'd13);
    check("pmid_no_ready", {31'd0, saw_ready}, 32'd0);
    check("pmid_count", {16'd0, pause_count}, 32'd1);
    cyc();
    pause_apply = 1'b0;
    @(negedge tx_clk);
    check("pmid_still_paused", {31'd0, paused}, 32'd1);
    cyc();
    @(negedge tx_clk);
    check("pmid_unpaused", {31'd0, paused}, 32'd0);
    cyc();

    // Pause and in_valid together in IDLE: pause wins.
    pause_apply = 1'b1; in_valid = 1'b1; in_data = 8'h5A; in_last = 1'b1;
    @(negedge tx_clk);
    check("pidle_ready0", {31'd0, in_ready}, 32'd0);
    cyc();
    @(negedge tx_clk);
    check("pidle_paused",  {31'd0, paused},      32'd1);
    check("pidle_ready1",  {31'd0, in_ready},    32'd0);
    check("pidle_valid",   {31'd0, out_valid},   32'd0);
    check("pidle_count",   {16'd0, pause_count}, 32'd2);
    cyc();
    pause_apply = 1'b0;
    cyc();
    @(negedge tx_clk);
    check("pidle_release",  {31'd0, paused},    32'd0);
    check("pidle_idle_val", {31'd0, out_valid}, 32'd0);
    cyc();
    @(negedge tx_clk);
    check("pidle_start_valid", {31'd0, out_valid}, 32'd1);
    check("pidle_start_data",  {24'd0, out_data},  32'h5A);
    check("pidle_start_last",  {31'd0, out_last},  32'd1);
    cyc();
    in_valid = 1'b0; in_last = 1'b0;
    repeat (14) cyc();

    // Backpressure: out_ready follows 1,0,0 repeating across a 5-byte frame.
    bp_seq = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'h00, 8'h00, 8'h00};
    bp_pat = 3'b001;
    in_valid = 1'b1; in_data = bp_seq[0]; in_last = 1'b0;
    cyc();
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      if (idx >= 5) break;
      out_ready = bp_pat[c % 3];
      in_data   = bp_seq[idx];
      in_last   = (idx == 4);
      @(negedge tx_clk);
      check("bp_ready_mirror", {31'd0, in_ready}, {31'd0, out_ready});
      if (out_valid && out_ready) begin
        check("bp_data", {24'd0, out_data}, {24'd0, bp_seq[idx]});
        idx++;
      end
      cyc();
    end
    check("bp_beats", idx, 32'd5);
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (14) cyc();

    // Saturation: preload near the top, then three more pause entries.
    force dut.pause_count_q = 16'hFFFD;
    cyc();
    release dut.pause_count_q;
    for (int e = 0; e < 3; e++) begin
      pause_apply = 1'b1;
      cyc();
      check("sat_count", {16'd0, pause_count}, (e == 0) ? 32'hFFFE : 32'hFFFF);
      pause_apply = 1'b0;
      cyc();
    end

    // Reset while byte 3 of a frame is on the bus.
    in_valid = 1'b1; in_data = 8'h01; in_last = 1'b0;
    cyc();
    cyc();
    in_data = 8'h02;
    cyc();
    in_data = 8'h03;
    @(negedge tx_clk);
    check("rmid_byte3", {24'd0, out_data}, 32'h03);
    rst = 1'b1;
    #1;
    check("rmid_valid",  {31'd0, out_valid},   32'd0);
    check("rmid_ready",  {31'd0, in_ready},    32'd0);
    check("rmid_paused", {31'd0, paused},      32'd0);
    check("rmid_count",  {16'd0, pause_count}, 32'd0);
    in_valid = 1'b0;
    @(posedge tx_clk);
    @(negedge tx_clk);
    rst = 1'b0;
    cyc();
    fr = '{8'hD1, 8'hD2, 8'hD3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(fr, 3, -1, "rnew");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
